mem_port_arbiter: RTL

- Shares the single-port instruction/data memory between three requesters:
  - the instruction fetch path, driven by the controller's fetch pulse;
  - the LDRI/STR data path;
  - the external program loader, used while the core is held in INIT.
- Serialises the requests, drives the memory port, and returns read data with a one-cycle acknowledge per access.
- Sits between the controller/datapath and the memory macro, replacing direct en_fetch/en_ldr/en_str wiring to the memory.

---
 rtl/mem_port_arbiter.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter for the shared single-port instruction/data memory: serialises fetch,
// LDRI/STR data and program-loader accesses, one in flight at a time.
module mem_port_arbiter #(
    parameter int unsigned AW         = 8,
    parameter int unsigned DW         = 16,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    // fetch requester
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_ack,
    output logic [DW-1:0] f_rdata,
    // data requester
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    // loader requester
    input  logic          l_req,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_ack,
    // memory port
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    // status
    output logic [1:0]    owner,
    output logic          busy
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    localparam logic [SW-1:0] StarveMax = SW'(STARVE_MAX);
    localparam logic [1:0]    WaitLast  = 2'(RD_LAT - 1);

    localparam logic [1:0] OwnNone  = 2'b00;
    localparam logic [1:0] OwnFetch = 2'b01;
    localparam logic [1:0] OwnData  = 2'b10;
    localparam logic [1:0] OwnLoad  = 2'b11;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e        state_q, state_d;
    logic [1:0]    owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [1:0]    wait_q, wait_d;
    logic [DW-1:0] f_rdata_q, f_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic          f_ack_q, f_ack_d;
    logic          d_ack_q, d_ack_d;
    logic          l_ack_q, l_ack_d;
    logic          busy_q, busy_d;
    logic [1:0]    grant;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        starve_d  = starve_q;
        wait_d    = wait_q;
        f_rdata_d = f_rdata_q;
        d_rdata_d = d_rdata_q;
        mem_en_d  = 1'b0;
        mem_we_d  = 1'b0;
        grant     = OwnNone;

        unique case (state_q)
            StIdle: begin
                if (l_req || d_req || f_req) begin
                    // Data normally beats fetch unless fetch has lost STARVE_MAX times running.
                    if (l_req) begin
                        grant = OwnLoad;
                    end else if (d_req && !(f_req && starve_q == StarveMax)) begin
                        grant = OwnData;
                    end else begin
                        grant = OwnFetch;
                    end

                    if (f_req) begin
                        if (grant == OwnFetch) begin
                            starve_d = '0;
                        end else if (starve_q != StarveMax) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end

                    unique case (grant)
                        OwnLoad: begin
                            addr_d  = l_addr;
                            wdata_d = l_wdata;
                            we_d    = 1'b1;
                        end
                        OwnData: begin
                            addr_d  = d_addr;
                            wdata_d = d_wdata;
                            we_d    = d_we;
                        end
                        default: begin
                            addr_d = f_addr;
                            we_d   = 1'b0;
                        end
                    endcase

                    owner_d  = grant;
                    mem_en_d = 1'b1;
                    mem_we_d = we_d;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                wait_d  = '0;
                state_d = we_q ? StDone : StWait;
            end
            StWait: begin
                if (wait_q == WaitLast) begin
                    if (owner_q == OwnFetch) begin
                        f_rdata_d = mem_rdata;
                    end else begin
                        d_rdata_d = mem_rdata;
                    end
                    state_d = StDone;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StDone: begin
                owner_d = OwnNone;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // DONE is entered from ISSUE or WAIT only, so owner_q still names the requester.
        f_ack_d = (state_d == StDone) && (owner_q == OwnFetch);
        d_ack_d = (state_d == StDone) && (owner_q == OwnData);
        l_ack_d = (state_d == StDone) && (owner_q == OwnLoad);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            owner_q   <= OwnNone;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            starve_q  <= '0;
            wait_q    <= '0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            f_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            l_ack_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            starve_q  <= starve_d;
            wait_q    <= wait_d;
            f_rdata_q <= f_rdata_d;
            d_rdata_q <= d_rdata_d;
            mem_en_q  <= mem_en_d;
            mem_we_q  <= mem_we_d;
            f_ack_q   <= f_ack_d;
            d_ack_q   <= d_ack_d;
            l_ack_q   <= l_ack_d;
            busy_q    <= busy_d;
        end
    end

    assign f_ack     = f_ack_q;
    assign f_rdata   = f_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign l_ack     = l_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign owner     = owner_q;
    assign busy      = busy_q;

    ack_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0({f_ack, d_ack, l_ack}));

endmodule
